shift_result_display: RTL
=========================

SHIFT_RESULT_DISPLAY -- requirements
Module: shift_result_display

Interface
REQ-001 The block SHALL take parameter N, default 8: width of the shifter result consumed.
REQ-002 The block SHALL take parameter REFRESH_DIV, default 50000: clock cycles per digit-scan tick, minimum 2.
REQ-003 The block SHALL use local constant D = ceil(N/4): number of hex digits displayed.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port result, input, N bits: shifter output to display.
REQ-007 The block SHALL have port result_valid, input, 1 bit: result is presented for capture.
REQ-008 The block SHALL have port result_ready, output, 1 bit: capture occurs this cycle if result_valid=1.
REQ-009 The block SHALL have port clear, input, 1 bit: synchronous request to blank the display.
REQ-010 The block SHALL have port seg, output, 7 bits: active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-011 The block SHALL have port an, output, D bits: active-low digit enables; an[0] is the least significant hex digit.

Function
REQ-012 The block SHALL implement an FSM with states BLANK and SCAN.
REQ-013 BLANK: result_ready=1; an all 1; seg=7'h7F; divider and digit index held at 0.
REQ-014 BLANK with result_valid=1: result captured into a display register; next state SCAN.
REQ-015 SCAN: divider counts 0..REFRESH_DIV-1 and wraps; tick = (divider==REFRESH_DIV-1).
REQ-016 SCAN: digit index increments on tick and wraps from D-1 to 0.
REQ-017 SCAN: exactly one an bit is low, an[digit index]; seg = hex pattern of display-register nibble [4*idx+3:4*idx].
REQ-018 Nibbles above bit N-1 SHALL read as zero (zero-extension of the top digit).
REQ-019 Hex patterns (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-020 SCAN: result_ready=1 only on the frame-boundary cycle (tick AND digit index==D-1); 0 otherwise.
REQ-021 Capture in SCAN SHALL occur only when result_ready and result_valid are both 1; the new value is displayed from digit 0 on the next cycle, so no frame ever mixes old and new nibbles.
REQ-022 result_valid held high without ready SHALL NOT alter the display; the upstream stage holds result until ready.
REQ-023 clear=1 in any state: next state BLANK, display register to 0; clear has priority over a simultaneous capture.
REQ-024 seg and an SHALL be combinational from registered state only, with no combinational path from result or result_valid.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state BLANK, divider 0, digit index 0, display register 0.
REQ-026 While rst_n=0: an all 1, seg=7'h7F, result_ready=1; reset mid-scan abandons the frame without a glitch frame on release.

Configuration
REQ-027 Macro BLANK_LEADING_ZEROS_EN: when defined, SCAN digits above the most significant nonzero nibble SHALL drive their an bit 1 and seg 7'h7F, a display value of 0 SHALL show a single "0" on digit 0, and scan timing SHALL be unchanged.
REQ-028 When BLANK_LEADING_ZEROS_EN is undefined, all D digits SHALL always be shown, including leading zeros.

Verification (N=8, REFRESH_DIV=4, D=2)
REQ-029 Reset, then idle for 20 cycles -> an=2'b11, seg=7F, result_ready=1 throughout.
REQ-030 In BLANK, result=8'hA5 with valid for one cycle -> next cycle an=2'b10 and seg=12 for 4 cycles, then an=2'b01 and seg=08 for 4 cycles, repeating.
REQ-031 Mid-frame, result=8'h3C with valid held -> result_ready pulses only at digit1 tick; display changes to 3C starting at digit 0; no frame shows C5 or A3.
REQ-032 clear and valid (8'hFF) asserted in the same cycle -> BLANK; an=2'b11; display register 0.
REQ-033 rst_n pulsed low for 1 cycle at a non-edge time during SCAN -> an=2'b11 immediately; after release, BLANK with result_ready=1.
REQ-034 With BLANK_LEADING_ZEROS_EN, capture 8'h07 -> digit 1 blank (an[1]=1, seg 7F), digit 0 seg=78; capture 8'h00 -> single "0" (seg 40) on digit 0 only.

Source files
------------

// File: rtl/shift_result_display.sv
// Hex display scanner for a shifter result: captures one value per frame and multiplexes its digits.
// Optional build macro BLANK_LEADING_ZEROS_EN suppresses digits above the most significant nonzero nibble.
//
// state | meaning
// BLANK | display dark, always ready to capture
// SCAN  | digits multiplexed; new capture accepted only at the frame boundary
module shift_result_display #(
  parameter int N           = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         result,
  input  logic                 result_valid,
  output logic                 result_ready,
  input  logic                 clear,
  output logic [6:0]           seg,
  output logic [(N+3)/4-1:0]   an
);

  localparam int D  = (N + 3) / 4;
  localparam int W  = 4 * D;
  localparam int DW = $clog2(REFRESH_DIV);
  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam logic [DW-1:0] DIV_TC   = DW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(D - 1);

  typedef enum logic {BLANK, SCAN} state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N-1:0]   disp_q, disp_d;
  logic           tick, frame_end;

  assign tick      = (state_q == SCAN) && (div_q == DIV_TC);
  assign frame_end = tick && (idx_q == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BLANK;
      div_q   <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    idx_d        = idx_q;
    disp_d       = disp_q;
    result_ready = 1'b0;
    case (state_q)
      BLANK: begin
        result_ready = 1'b1;
        div_d        = '0;
        idx_d        = '0;
        if (result_valid) begin
          disp_d  = result;
          state_d = SCAN;
        end
      end
      SCAN: begin
        result_ready = frame_end;
        div_d        = tick ? '0 : div_q + 1'b1;
        if (tick)
          idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        // the index wraps to 0 on the same edge, so a new value starts at digit 0
        if (frame_end && result_valid)
          disp_d = result;
      end
      default: state_d = BLANK;
    endcase
    if (clear) begin
      state_d = BLANK;
      disp_d  = '0;
      div_d   = '0;
      idx_d   = '0;
    end
  end

  logic [W-1:0]  disp_ext;
  logic [3:0]    nibble;
  logic          shown;
  logic [IW-1:0] msd;

  assign disp_ext = W'(disp_q);

  always_comb begin
    nibble = 4'h0;
    msd    = '0;
    for (int i = 0; i < D; i++) begin
      if (idx_q == IW'(i))
        nibble = disp_ext[4*i +: 4];
      if (disp_ext[4*i +: 4] != 4'h0)
        msd = IW'(i);
    end
`ifdef BLANK_LEADING_ZEROS_EN
    shown = (idx_q <= msd);
`else
    shown = 1'b1;
`endif
  end

  always_comb begin
    seg = 7'h7F;
    an  = '1;
    if (state_q == SCAN && shown) begin
      for (int i = 0; i < D; i++)
        an[i] = (idx_q != IW'(i));
      case (nibble)
        4'h0: seg = 7'h40;
        4'h1: seg = 7'h79;
        4'h2: seg = 7'h24;
        4'h3: seg = 7'h30;
        4'h4: seg = 7'h19;
        4'h5: seg = 7'h12;
        4'h6: seg = 7'h02;
        4'h7: seg = 7'h78;
        4'h8: seg = 7'h00;
        4'h9: seg = 7'h10;
        4'hA: seg = 7'h08;
        4'hB: seg = 7'h03;
        4'hC: seg = 7'h46;
        4'hD: seg = 7'h21;
        4'hE: seg = 7'h06;
        default: seg = 7'h0E;
      endcase
    end
  end

endmodule
